// File: rtl/mem_ctrl_burst_if.sv
// rtl/mem_ctrl_burst_if.sv - FWFT command FIFO to fixed-latency BRAM burst engine
module mem_ctrl_burst_if #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 4,
    parameter int RD_LAT    = 1,
    parameter int MEM_DEPTH = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2+LEN_W+ADDR_W+DATA_W-1:0]  cmd_fifo_data,
    input  logic                              cmd_fifo_empty,
    output logic                              cmd_fifo_rd_en,
    input  logic                              resp_fifo_full,
    output logic                              resp_fifo_wr_en,
    output logic [DATA_W-1:0]                 resp_fifo_data,
    output logic                              resp_fifo_err,
    output logic                              bram_en,
    output logic                              bram_we,
    output logic [ADDR_W-1:0]                 bram_addr,
    output logic [DATA_W-1:0]                 bram_din,
    input  logic [DATA_W-1:0]                 bram_dout,
    output logic                              busy,
    output logic [15:0]                       err_count
);
    localparam int CMD_W = 2 + LEN_W + ADDR_W + DATA_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_BEAT  = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_RESP  = 3'd4;
    localparam logic [2:0] S_ERR_RESP = 3'd5;

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [2:0]      LAT_LAST = 3'(RD_LAT - 1);

    logic [1:0]        f_op;
    logic [LEN_W-1:0]  f_len;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_wdata;

    assign f_op    = cmd_fifo_data[CMD_W-1 -: 2];
    assign f_len   = cmd_fifo_data[ADDR_W+DATA_W +: LEN_W];
    assign f_addr  = cmd_fifo_data[DATA_W +: ADDR_W];
    assign f_wdata = cmd_fifo_data[DATA_W-1:0];

    logic [2:0]        state;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  beat;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] wdata_r;
    logic [2:0]        lat_cnt;
    logic              beat_oor;

    logic [ADDR_W-1:0] nb_addr;
    logic              nb_ok;
    logic              err_inc;

    // Address/range of the beat about to be launched, and whether this edge counts an error beat
    always_comb begin
        nb_addr = (state == S_IDLE) ? f_addr : cur_addr + ADDR_W'(1);
        nb_ok   = ({1'b0, nb_addr} < DEPTH_L);
        err_inc = 1'b0;
        case (state)
            S_IDLE:    if (!cmd_fifo_empty) err_inc = (f_op == 2'b11) || !nb_ok;
            S_WR_BEAT: if (beat != len_r) err_inc = !nb_ok;
            S_RD_RESP: if (!resp_fifo_full && beat != len_r) err_inc = !nb_ok;
            default:   err_inc = 1'b0;
        endcase
    end

    // Command FSM; every output is registered and launched on the edge that enters its state
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            len_r           <= '0;
            beat            <= '0;
            cur_addr        <= '0;
            wdata_r         <= '0;
            lat_cnt         <= '0;
            beat_oor        <= 1'b0;
            cmd_fifo_rd_en  <= 1'b0;
            resp_fifo_wr_en <= 1'b0;
            resp_fifo_data  <= '0;
            resp_fifo_err   <= 1'b0;
            bram_en         <= 1'b0;
            bram_we         <= 1'b0;
            bram_addr       <= '0;
            bram_din        <= '0;
            busy            <= 1'b0;
            err_count       <= '0;
        end else begin
            cmd_fifo_rd_en  <= 1'b0;
            resp_fifo_wr_en <= 1'b0;
            if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            case (state)
                S_IDLE: begin
                    if (!cmd_fifo_empty) begin
                        cmd_fifo_rd_en <= 1'b1;
                        busy           <= 1'b1;
                        len_r          <= f_len;
                        beat           <= '0;
                        cur_addr       <= f_addr;
                        wdata_r        <= f_wdata;
                        case (f_op)
                            2'b01: begin
                                state     <= S_WR_BEAT;
                                bram_en   <= nb_ok;
                                bram_we   <= nb_ok;
                                bram_addr <= f_addr;
                                bram_din  <= f_wdata;
                            end
                            2'b11: begin
                                state          <= S_ERR_RESP;
                                resp_fifo_data <= '0;
                                resp_fifo_err  <= 1'b1;
                            end
                            default: begin
                                state     <= S_RD_ISSUE;
                                bram_en   <= nb_ok;
                                bram_we   <= 1'b0;
                                bram_addr <= f_addr;
                                beat_oor  <= !nb_ok;
                            end
                        endcase
                    end
                end
                S_WR_BEAT: begin
                    if (beat == len_r) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        bram_en <= 1'b0;
                        bram_we <= 1'b0;
                    end else begin
                        beat      <= beat + LEN_W'(1);
                        cur_addr  <= nb_addr;
                        bram_en   <= nb_ok;
                        bram_we   <= nb_ok;
                        bram_addr <= nb_addr;
                        bram_din  <= wdata_r;
                    end
                end
                S_RD_ISSUE: begin
                    bram_en <= 1'b0;
                    if (beat_oor) begin
                        resp_fifo_data <= '0;
                        resp_fifo_err  <= 1'b1;
                        state          <= S_RD_RESP;
                    end else begin
                        lat_cnt <= '0;
                        state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        resp_fifo_data <= bram_dout;
                        resp_fifo_err  <= 1'b0;
                        state          <= S_RD_RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_RD_RESP: begin
                    if (!resp_fifo_full) begin
                        resp_fifo_wr_en <= 1'b1;
                        if (beat == len_r) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            beat      <= beat + LEN_W'(1);
                            cur_addr  <= nb_addr;
                            bram_en   <= nb_ok;
                            bram_we   <= 1'b0;
                            bram_addr <= nb_addr;
                            beat_oor  <= !nb_ok;
                            state     <= S_RD_ISSUE;
                        end
                    end
                end
                S_ERR_RESP: begin
                    if (!resp_fifo_full) begin
                        resp_fifo_wr_en <= 1'b1;
                        state           <= S_IDLE;
                        busy            <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl_burst_if.sv
// tb/tb_mem_ctrl_burst_if.sv - table-driven bench for mem_ctrl_burst_if
module tb_mem_ctrl_burst_if;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 4;
    localparam int RD_LAT    = 2;
    localparam int MEM_DEPTH = 200;
    localparam int CMD_W     = 2 + LEN_W + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [CMD_W-1:0]  cmd_fifo_data;
    logic              cmd_fifo_empty;
    logic              cmd_fifo_rd_en;
    logic              resp_fifo_full;
    logic              resp_fifo_wr_en;
    logic [DATA_W-1:0] resp_fifo_data;
    logic              resp_fifo_err;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;
    logic              busy;
    logic [15:0]       err_count;

    mem_ctrl_burst_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_fifo_data(cmd_fifo_data), .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_rd_en(cmd_fifo_rd_en),
        .resp_fifo_full(resp_fifo_full), .resp_fifo_wr_en(resp_fifo_wr_en),
        .resp_fifo_data(resp_fifo_data), .resp_fifo_err(resp_fifo_err),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // FWFT command FIFO model
    logic [CMD_W-1:0] cmd_mem [0:63];
    int cmd_wr = 0;
    int cmd_rd = 0;
    assign cmd_fifo_empty = (cmd_wr == cmd_rd);
    assign cmd_fifo_data  = cmd_mem[cmd_rd[5:0]];
    always @(posedge clk) if (cmd_fifo_rd_en) cmd_rd <= cmd_rd + 1;

    // BRAM model; read data is valid only in the single cycle RD_LAT after the strobe
    logic [7:0] mem [0:255];
    logic [7:0] rd_pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_din;
        rd_pipe[0] <= (bram_en && !bram_we) ? mem[bram_addr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_dout = rd_pipe[RD_LAT-1];

    // Output monitors
    logic [7:0] rsp_d [0:255];
    logic       rsp_e [0:255];
    logic [7:0] wr_a  [0:255];
    logic [7:0] wr_v  [0:255];
    int rsp_n = 0, en_n = 0, wr_n = 0, pop_n = 0, viol = 0;
    always @(negedge clk) begin
        if (resp_fifo_wr_en && rsp_n < 256) begin
            rsp_d[rsp_n] = resp_fifo_data;
            rsp_e[rsp_n] = resp_fifo_err;
            rsp_n++;
            if (resp_fifo_full) viol++;
        end
        if (bram_en) begin
            en_n++;
            if (bram_we && wr_n < 256) begin
                wr_a[wr_n] = bram_addr;
                wr_v[wr_n] = bram_din;
                wr_n++;
            end
        end
        if (cmd_fifo_rd_en) pop_n++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [3:0] len,
                            input logic [7:0] addr, input logic [7:0] wdata);
        cmd_mem[cmd_wr[5:0]] = {op, len, addr, wdata};
        cmd_wr++;
    endtask

    task automatic wait_idle(input string name);
        int idle = 0;
        int cyc  = 0;
        while (idle < 3 && cyc < 400) begin
            @(negedge clk); #1;
            cyc++;
            if (cmd_fifo_empty && !busy && !cmd_fifo_rd_en) idle++;
            else idle = 0;
        end
        checks++;
        if (idle < 3) begin
            errors++;
            $display("FAIL %s_timeout: busy=%0d still high after %0d cycles, required idle", name, busy, cyc);
        end
    endtask

    task automatic wait_resp(input string name, input int target);
        int cyc = 0;
        while (rsp_n < target && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        check(name, rsp_n, target);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  len;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        int          n_resp;
        logic [7:0]  rdata;
        logic [15:0] err_mask;
        int          n_en;
        int          n_wr;
        int          n_err;
    } vec_t;

    vec_t v [0:14];
    int   exp_err;
    int   b_rsp, b_en, b_wr, b_pop, wi, cyc;
    logic [7:0] held, a;

    initial begin
        //         op     len   addr   wdata  resp data   mask     en wr err
        v[0]  = '{2'b01, 4'd0, 8'h10, 8'hA5, 0, 8'h00, 16'h0000, 1, 1, 0};
        v[1]  = '{2'b00, 4'd0, 8'h10, 8'h00, 1, 8'hA5, 16'h0000, 1, 0, 0};
        v[2]  = '{2'b01, 4'd3, 8'hFE, 8'h3C, 0, 8'h00, 16'h0000, 2, 2, 2};
        v[3]  = '{2'b00, 4'd3, 8'hFE, 8'h00, 4, 8'h3C, 16'h0003, 2, 0, 2};
        v[4]  = '{2'b01, 4'd1, 8'hC6, 8'h5A, 0, 8'h00, 16'h0000, 2, 2, 0};
        v[5]  = '{2'b00, 4'd3, 8'hC6, 8'h00, 4, 8'h5A, 16'h000C, 2, 0, 2};
        v[6]  = '{2'b11, 4'd2, 8'h10, 8'h00, 1, 8'h00, 16'h0001, 0, 0, 1};
        v[7]  = '{2'b10, 4'd1, 8'h00, 8'h00, 2, 8'h3C, 16'h0000, 2, 0, 0};
        v[8]  = '{2'b01, 4'd0, 8'h30, 8'h11, 0, 8'h00, 16'h0000, 1, 1, 0};
        v[9]  = '{2'b01, 4'd0, 8'h31, 8'h22, 0, 8'h00, 16'h0000, 1, 1, 0};
        v[10] = '{2'b01, 4'd0, 8'h32, 8'h33, 0, 8'h00, 16'h0000, 1, 1, 0};
        v[11] = '{2'b01, 4'd2, 8'h20, 8'h77, 0, 8'h00, 16'h0000, 3, 3, 0};
        v[12] = '{2'b00, 4'd1, 8'h21, 8'h00, 2, 8'h77, 16'h0000, 2, 0, 0};
        v[13] = '{2'b00, 4'd0, 8'hC7, 8'h00, 1, 8'h5A, 16'h0000, 1, 0, 0};
        v[14] = '{2'b00, 4'd0, 8'hC8, 8'h00, 1, 8'h00, 16'h0001, 0, 0, 1};

        rst = 1'b1;
        resp_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rd_en",   cmd_fifo_rd_en, 0);
        check("rst_wr_en",   resp_fifo_wr_en, 0);
        check("rst_rdata",   resp_fifo_data, 0);
        check("rst_err",     resp_fifo_err, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_addr",    bram_addr, 0);
        check("rst_din",     bram_din, 0);
        check("rst_busy",    busy, 0);
        check("rst_errcnt",  err_count, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        exp_err = 0;
        for (int i = 0; i < 15; i++) begin
            b_rsp = rsp_n; b_en = en_n; b_wr = wr_n; b_pop = pop_n;
            push_cmd(v[i].op, v[i].len, v[i].addr, v[i].wdata);
            wait_idle($sformatf("v%0d", i));
            exp_err += v[i].n_err;
            check($sformatf("v%0d_pops", i), pop_n - b_pop, 1);
            check($sformatf("v%0d_nresp", i), rsp_n - b_rsp, v[i].n_resp);
            for (int k = 0; k < v[i].n_resp; k++) begin
                check($sformatf("v%0d_b%0d_err", i, k), rsp_e[b_rsp+k], v[i].err_mask[k]);
                check($sformatf("v%0d_b%0d_data", i, k), rsp_d[b_rsp+k],
                      v[i].err_mask[k] ? 8'h00 : v[i].rdata);
            end
            check($sformatf("v%0d_bram_en", i), en_n - b_en, v[i].n_en);
            check($sformatf("v%0d_nwr", i), wr_n - b_wr, v[i].n_wr);
            if (v[i].op == 2'b01) begin
                wi = b_wr;
                for (int k = 0; k <= int'(v[i].len); k++) begin
                    a = v[i].addr + 8'(k);
                    if (int'(a) < MEM_DEPTH) begin
                        check($sformatf("v%0d_wr%0d_addr", i, k), wr_a[wi], a);
                        check($sformatf("v%0d_wr%0d_data", i, k), wr_v[wi], v[i].wdata);
                        wi++;
                    end
                end
            end
            check($sformatf("v%0d_errcnt", i), err_count, exp_err);
            check($sformatf("v%0d_busy", i), busy, 0);
        end

        // Backpressure on beat 1 of a 3-beat read
        b_rsp = rsp_n;
        push_cmd(2'b00, 4'd2, 8'h30, 8'h00);
        wait_resp("bp_first_push", b_rsp + 1);
        resp_fifo_full = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        held = resp_fifo_data;
        repeat (5) @(negedge clk);
        #1;
        check("bp_no_push_while_full", rsp_n - b_rsp, 1);
        check("bp_data_held", resp_fifo_data, held);
        check("bp_held_value", resp_fifo_data, 8'h22);
        resp_fifo_full = 1'b0;
        wait_idle("bp");
        check("bp_total", rsp_n - b_rsp, 3);
        check("bp_d0", rsp_d[b_rsp],   8'h11);
        check("bp_d1", rsp_d[b_rsp+1], 8'h22);
        check("bp_d2", rsp_d[b_rsp+2], 8'h33);
        check("bp_e",  {rsp_e[b_rsp], rsp_e[b_rsp+1], rsp_e[b_rsp+2]}, 0);
        check("bp_wr_while_full", viol, 0);

        // Reset in the middle of an 8-beat read
        b_rsp = rsp_n; b_pop = pop_n;
        push_cmd(2'b00, 4'd7, 8'h00, 8'h00);
        wait_resp("mid_three_resp", b_rsp + 3);
        rst = 1'b1;
        @(negedge clk); #1;
        check("mid_rst_outs", {cmd_fifo_rd_en, resp_fifo_wr_en, resp_fifo_err, bram_en, bram_we, busy}, 0);
        check("mid_rst_data", {resp_fifo_data, bram_addr, bram_din}, 0);
        check("mid_rst_errcnt", err_count, 0);
        rst = 1'b0;
        cyc = 0;
        repeat (30) @(negedge clk);
        #1;
        check("mid_no_more_push", rsp_n - b_rsp, 3);
        check("mid_pops", pop_n - b_pop, 1);
        check("mid_busy", busy, 0);
        b_rsp = rsp_n;
        push_cmd(2'b00, 4'd0, 8'h10, 8'h00);
        wait_idle("post_rst");
        check("post_rst_nresp", rsp_n - b_rsp, 1);
        check("post_rst_data", rsp_d[b_rsp], 8'hA5);
        check("post_rst_err", rsp_e[b_rsp], 0);
        check("post_rst_errcnt", err_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end
endmodule
